// File: rtl/rocket_audio_pkg.sv
// Shared audio-path definitions: default widths, select normalisation and the
// matrix sequencer state type, reused by the mixer/echo successors.
package rocket_audio_pkg;
   localparam int BITSIZE_DEF   = 16;
   localparam int FADE_BITS_DEF = 6;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SWEEP, ST_DONE} xfade_state_e;

   function automatic int sel_mute(input int n_in);
      return n_in;
   endfunction

   // Any select code at or beyond the input count collapses onto the MUTE code.
   function automatic int norm_sel(input int sel, input int n_in);
      return (sel >= n_in) ? sel_mute(n_in) : sel;
   endfunction

   function automatic int fade_len(input int fade_bits);
      return 1 << fade_bits;
   endfunction

   function automatic int mac_width(input int bitsize, input int fade_bits);
      return bitsize + fade_bits + 2;
   endfunction
endpackage

// File: rtl/mod_matrix_xfade_if.sv
// Sample-side bus of the routing matrix: strobe, input/select buses in,
// routed outputs and status out.
interface mod_matrix_xfade_if #(
   parameter int BITSIZE = 16,
   parameter int N_IN    = 9,
   parameter int N_OUT   = 11
);
   localparam int SELW = $clog2(N_IN + 1);

   logic                     sample_strobe;
   logic [N_IN*BITSIZE-1:0]  in_bus;
   logic [N_OUT*SELW-1:0]    sel_bus;
   logic [N_OUT*BITSIZE-1:0] out_bus;
   logic                     out_valid;
   logic                     busy;
   logic [N_OUT-1:0]         fading;
   logic                     overrun;

   modport master (
      output sample_strobe, in_bus, sel_bus,
      input  out_bus, out_valid, busy, fading, overrun
   );

   modport slave (
      input  sample_strobe, in_bus, sel_bus,
      output out_bus, out_valid, busy, fading, overrun
   );
endinterface

// File: rtl/xfade_mac.sv
// Combinational crossfade MAC: y = (a*(F-k) + b*k) >>> FADE_BITS, floor rounding.
module xfade_mac
   import rocket_audio_pkg::*;
#(
   parameter int BITSIZE   = BITSIZE_DEF,
   parameter int FADE_BITS = FADE_BITS_DEF
)(
   input  logic signed [BITSIZE-1:0] a_i,
   input  logic signed [BITSIZE-1:0] b_i,
   input  logic        [FADE_BITS:0] k_i,
   output logic signed [BITSIZE-1:0] y_o
);
   localparam int W = mac_width(BITSIZE, FADE_BITS);
   localparam int F = fade_len(FADE_BITS);

   // The weights sum to F, so the shifted result always fits back in BITSIZE.
   function automatic logic signed [BITSIZE-1:0] floor_shift(input logic signed [W-1:0] acc);
      return BITSIZE'(acc >>> FADE_BITS);
   endfunction

   logic signed [W-1:0] a_w, b_w, ka_w, kb_w, acc;

   always_comb begin
      a_w  = W'(a_i);
      b_w  = W'(b_i);
      kb_w = signed'(W'(k_i));
      ka_w = signed'(W'(F)) - kb_w;
      acc  = a_w * ka_w + b_w * kb_w;
      y_o  = floor_shift(acc);
   end
endmodule

// File: rtl/mod_matrix_xfade.sv
// N_IN x N_OUT routing matrix with per-output crossfade on selection change;
// one shared MAC evaluates one output per clock during the sweep.
module mod_matrix_xfade
   import rocket_audio_pkg::*;
#(
   parameter int BITSIZE   = BITSIZE_DEF,
   parameter int N_IN      = 9,
   parameter int N_OUT     = 11,
   parameter int FADE_BITS = FADE_BITS_DEF
)(
   input logic               clk,
   input logic               resetn,
   mod_matrix_xfade_if.slave bus
);
   localparam int SELW = $clog2(N_IN + 1);
   localparam int F    = fade_len(FADE_BITS);
   localparam int KW   = FADE_BITS + 1;
   localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [SELW-1:0] MUTE   = SELW'(sel_mute(N_IN));
   localparam logic [KW-1:0]   K_FULL = KW'(F);

   xfade_state_e              state_q, state_d;
   logic [JW-1:0]             j_q, j_d;
   logic                      overrun_q;
   logic [N_OUT*BITSIZE-1:0]  out_q;
   logic [SELW-1:0]           active_q [N_OUT];
   logic [SELW-1:0]           target_q [N_OUT];
   logic [KW-1:0]             k_q      [N_OUT];
   logic signed [BITSIZE-1:0] snap_q   [N_IN];
   logic signed [BITSIZE-1:0] shadow_q [N_OUT];

   logic [SELW-1:0]           sel_n [N_OUT];
   logic                      last_j;
   logic [SELW-1:0]           a_sel, b_sel;
   logic [KW-1:0]             k_cur;
   logic signed [BITSIZE-1:0] a_val, b_val, y;

   assign last_j = (j_q == JW'(N_OUT - 1));

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      case (state_q)
         ST_IDLE:  if (bus.sample_strobe) state_d = ST_LOAD;
         ST_LOAD:  begin
            state_d = ST_SWEEP;
            j_d     = '0;
         end
         ST_SWEEP: begin
            if (last_j) state_d = ST_DONE;
            else        j_d     = j_q + 1'b1;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      for (int o = 0; o < N_OUT; o++)
         sel_n[o] = SELW'(norm_sel(int'(bus.sel_bus[o*SELW +: SELW]), N_IN));
   end

   // Operand fetch for the output under the sweep pointer; MUTE matches no input and reads 0.
   always_comb begin
      a_sel = MUTE;
      b_sel = MUTE;
      k_cur = K_FULL;
      for (int o = 0; o < N_OUT; o++) begin
         if (j_q == JW'(o)) begin
            a_sel = active_q[o];
            b_sel = target_q[o];
            k_cur = k_q[o];
         end
      end
      a_val = '0;
      b_val = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (a_sel == SELW'(i)) a_val = snap_q[i];
         if (b_sel == SELW'(i)) b_val = snap_q[i];
      end
   end

   xfade_mac #(
      .BITSIZE   (BITSIZE),
      .FADE_BITS (FADE_BITS)
   ) u_mac (
      .a_i (a_val),
      .b_i (b_val),
      .k_i (k_cur),
      .y_o (y)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         j_q       <= '0;
         overrun_q <= 1'b0;
         out_q     <= '0;
         for (int o = 0; o < N_OUT; o++) begin
            active_q[o] <= MUTE;
            target_q[o] <= MUTE;
            k_q[o]      <= K_FULL;
         end
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         if (bus.sample_strobe && (state_q != ST_IDLE)) overrun_q <= 1'b1;
         // A new selection is only accepted once the previous fade has finished.
         if (state_q == ST_LOAD) begin
            for (int o = 0; o < N_OUT; o++) begin
               if (k_q[o] == K_FULL) begin
                  if (sel_n[o] != target_q[o]) begin
                     active_q[o] <= target_q[o];
                     target_q[o] <= sel_n[o];
                     k_q[o]      <= KW'(1);
                  end
               end else begin
                  k_q[o] <= k_q[o] + 1'b1;
               end
            end
         end
         // Publish the whole frame in one edge so out_bus is current during DONE.
         if ((state_q == ST_SWEEP) && last_j) begin
            for (int o = 0; o < N_OUT; o++)
               out_q[o*BITSIZE +: BITSIZE] <= (j_q == JW'(o)) ? y : shadow_q[o];
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == ST_IDLE) && bus.sample_strobe) begin
         for (int i = 0; i < N_IN; i++)
            snap_q[i] <= bus.in_bus[i*BITSIZE +: BITSIZE];
      end
      if (state_q == ST_SWEEP) begin
         for (int o = 0; o < N_OUT; o++)
            if (j_q == JW'(o)) shadow_q[o] <= y;
      end
   end

   assign bus.out_bus   = out_q;
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.overrun   = overrun_q;

   always_comb begin
      for (int o = 0; o < N_OUT; o++)
         bus.fading[o] = (k_q[o] != K_FULL);
   end
endmodule

// File: tb/tb_mod_matrix_xfade.sv
// Scoreboard bench for mod_matrix_xfade: stimulus pushes model results, a
// monitor pops them on out_valid; a second FADE_BITS=6 instance covers extremes.
`timescale 1ns/1ps
module tb_mod_matrix_xfade;
   localparam int B   = 16;
   localparam int NI  = 9;
   localparam int NO  = 11;
   localparam int FB  = 2;
   localparam int F   = 4;
   localparam int SW  = 4;
   localparam int NO6 = 2;
   localparam int F6  = 64;

   typedef struct {
      logic [NO*B-1:0] y;
      logic [NO-1:0]   fad;
      int              cyc;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   int   in_v  [NI];
   int   sel_v [NO];
   int   m_old [NO];
   int   m_new [NO];
   int   m_w   [NO];
   exp_t sb [$];
   exp_t mon_e;

   int exp2 [5] = '{250, 500, 750, 1000, 1000};
   int exp3 [5] = '{500, 0, -500, -1000, 7441};
   int offs [2] = '{5, 13};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mod_matrix_xfade_if #(.BITSIZE(B), .N_IN(NI), .N_OUT(NO))  bus ();
   mod_matrix_xfade_if #(.BITSIZE(B), .N_IN(NI), .N_OUT(NO6)) bus6 ();

   mod_matrix_xfade #(.BITSIZE(B), .N_IN(NI), .N_OUT(NO), .FADE_BITS(FB)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   mod_matrix_xfade #(.BITSIZE(B), .N_IN(NI), .N_OUT(NO6), .FADE_BITS(6)) dut6 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus6)
   );

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic longint floor_div(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint out_of(input int j);
      return longint'(signed'(bus.out_bus[j*B +: B]));
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < NO; j++) begin
         m_old[j] = NI;
         m_new[j] = NI;
         m_w[j]   = F;
      end
      sb.delete();
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NI; i++) bus.in_bus[i*B +: B] = B'(in_v[i]);
      for (int j = 0; j < NO; j++) bus.sel_bus[j*SW +: SW] = SW'(sel_v[j]);
   endtask

   // Each output blends old source and new source with weight w/F on the new one.
   task automatic issue_strobe();
      exp_t   e;
      int     s;
      longint a, b;
      drive_inputs();
      bus.sample_strobe = 1'b1;
      for (int j = 0; j < NO; j++) begin
         s = (sel_v[j] >= NI) ? NI : sel_v[j];
         if (m_w[j] == F) begin
            if (s != m_new[j]) begin
               m_old[j] = m_new[j];
               m_new[j] = s;
               m_w[j]   = 1;
            end
         end else begin
            m_w[j] = m_w[j] + 1;
         end
         a = (m_old[j] >= NI) ? 0 : longint'(in_v[m_old[j]]);
         b = (m_new[j] >= NI) ? 0 : longint'(in_v[m_new[j]]);
         e.y[j*B +: B] = B'(floor_div(a * (F - m_w[j]) + b * m_w[j], F));
         e.fad[j] = (m_w[j] != F);
      end
      e.cyc = cyc + NO + 2;
      sb.push_back(e);
      tick(1);
      bus.sample_strobe = 1'b0;
   endtask

   task automatic sample();
      issue_strobe();
      tick(NO + 2);
   endtask

   task automatic sample6();
      bus6.sample_strobe = 1'b1;
      tick(1);
      bus6.sample_strobe = 1'b0;
      tick(NO6 + 2);
   endtask

   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("valid_latency_cycle", longint'(cyc), longint'(mon_e.cyc));
            for (int j = 0; j < NO; j++)
               chk($sformatf("out_bus[%0d]", j), out_of(j), longint'(signed'(mon_e.y[j*B +: B])));
            chk("fading", longint'(bus.fading), longint'(mon_e.fad));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint y6, prev6;
      for (int i = 0; i < NI; i++) in_v[i] = 0;
      for (int j = 0; j < NO; j++) sel_v[j] = NI;
      bus.sample_strobe = 1'b0;
      bus.in_bus = '0;
      bus.sel_bus = '0;
      bus6.sample_strobe = 1'b0;
      bus6.in_bus = '0;
      bus6.sel_bus = '1;
      model_reset();
      drive_inputs();

      // reset state
      resetn = 1'b0;
      tick(3);
      chk("reset_out_valid", longint'(bus.out_valid), 0);
      chk("reset_busy", longint'(bus.busy), 0);
      chk("reset_overrun", longint'(bus.overrun), 0);
      chk("reset_fading", longint'(bus.fading), 0);
      for (int j = 0; j < NO; j++) chk("reset_out_bus", out_of(j), 0);
      resetn = 1'b1;
      tick(1);

      // all muted, latency and zero outputs
      sample();

      // fade in from MUTE
      in_v[0] = 1000;
      sel_v[0] = 0;
      for (int n = 0; n < 5; n++) begin
         sample();
         chk("fadein_out0", out_of(0), exp2[n]);
         chk("fadein_fading0", longint'(bus.fading[0]), (n < 3) ? 1 : 0);
      end

      // reselect mid-fade is ignored until the fade completes
      in_v[1] = -1000;
      in_v[2] = 32767;
      sel_v[0] = 1;
      for (int n = 0; n < 5; n++) begin
         sample();
         chk("midfade_out0", out_of(0), exp3[n]);
         sel_v[0] = 2;
      end
      chk("midfade_fading0", longint'(bus.fading[0]), 1);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NI; i++) begin
            case ($urandom_range(0, 7))
               0: in_v[i] = -32768;
               1: in_v[i] = 32767;
               2, 3, 4: in_v[i] = int'($urandom_range(0, 65535)) - 32768;
               default: ;
            endcase
         end
         for (int j = 0; j < NO; j++)
            if ($urandom_range(0, 3) == 0) sel_v[j] = int'($urandom_range(0, 15));
         sample();
      end

      // strobe while busy: in SWEEP and in DONE
      for (int t = 0; t < 2; t++) begin
         chk("overrun_before", longint'(bus.overrun), 0);
         issue_strobe();
         tick(offs[t] - 1);
         bus.sample_strobe = 1'b1;
         tick(1);
         bus.sample_strobe = 1'b0;
         chk("overrun_set", longint'(bus.overrun), 1);
         tick(NO + 2 - offs[t]);
         sample();
         chk("overrun_sticky", longint'(bus.overrun), 1);
         resetn = 1'b0;
         model_reset();
         tick(1);
         resetn = 1'b1;
         chk("overrun_cleared", longint'(bus.overrun), 0);
      end

      // reset in the middle of a sweep
      for (int j = 0; j < NO; j++) sel_v[j] = NI;
      in_v[0] = 1234;
      sel_v[0] = 0;
      repeat (4) sample();
      chk("pre_abort_out0", out_of(0), 1234);
      issue_strobe();
      tick(6);
      resetn = 1'b0;
      model_reset();
      tick(1);
      chk("abort_out0", out_of(0), 0);
      chk("abort_busy", longint'(bus.busy), 0);
      chk("abort_out_valid", longint'(bus.out_valid), 0);
      resetn = 1'b1;
      tick(NO + 3);
      sel_v[0] = 15;
      sample();
      chk("sel15_out0", out_of(0), 0);
      chk("sel15_fading0", longint'(bus.fading[0]), 0);
      sel_v[0] = 0;
      repeat (4) sample();
      sel_v[0] = 12;
      sample();
      chk("sel12_fade_to_zero", out_of(0), 925);

      // full-scale 64-step fade on the FADE_BITS=6 instance
      bus6.in_bus[3*B +: B] = 16'h8000;
      bus6.in_bus[4*B +: B] = 16'h7FFF;
      bus6.sel_bus[0 +: SW] = 4'd3;
      repeat (F6) sample6();
      chk("wide_settled_low", longint'(signed'(bus6.out_bus[0 +: B])), -32768);
      bus6.sel_bus[0 +: SW] = 4'd4;
      prev6 = -32768;
      for (int k = 1; k <= F6; k++) begin
         sample6();
         y6 = longint'(signed'(bus6.out_bus[0 +: B]));
         chk("wide_fade_value", y6, floor_div(-32768 * longint'(F6 - k) + 32767 * longint'(k), F6));
         chk("wide_fade_monotonic", (y6 >= prev6) ? 1 : 0, 1);
         prev6 = y6;
      end
      chk("wide_final", y6, 32767);
      chk("wide_fading0", longint'(bus6.fading[0]), 0);
      chk("wide_muted_out1", longint'(signed'(bus6.out_bus[B +: B])), 0);

      tick(5);
      chk("scoreboard_drained", longint'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
